// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// over XLEN iterations, with sign handling confined to the PREP and FIX states.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          f3_q, f3_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN:0]       rem_q, rem_d;
  logic                sa_q, sa_d, sb_q, sb_d, wrap_q, wrap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                is_div, sa_w, sb_w, borrow;
  logic [XLEN-1:0]     abs_a, abs_b, quo, rmd, fix_res;
  logic [XLEN:0]       mul_sum, div_diff;
  logic [XLEN+1:0]     div_shift;
  logic [2*XLEN-1:0]   mul_next, prod;

  assign is_div = f3_q[2];
  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
  assign sa_w   = a_q[XLEN-1] & (f3_q == 3'b001 || f3_q == 3'b010 || f3_q == 3'b100 || f3_q == 3'b110);
  assign sb_w   = b_q[XLEN-1] & (f3_q == 3'b001 || f3_q == 3'b100 || f3_q == 3'b110);
  assign abs_a  = sa_w ? (~a_q + 1'b1) : a_q;
  assign abs_b  = sb_w ? (~b_q + 1'b1) : b_q;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

  assign div_shift = {rem_q, a_q[XLEN-1]};
  assign borrow    = div_shift < {2'b00, b_q};
  assign div_diff  = div_shift[XLEN:0] - {1'b0, b_q};

  assign prod    = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
  assign quo     = (sa_q ^ sb_q) ? (~a_q + 1'b1) : a_q;
  assign rmd     = sa_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
  assign fix_res = is_div ? (f3_q[1] ? rmd : quo)
                          : ((f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    wrap_d   = wrap_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          state_d = S_PREP;
          f3_d    = funct3;
          a_d     = op_a;
          b_d     = op_b;
        end
      end
      S_PREP: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          sa_d   = sa_w;
          sb_d   = sb_w;
          a_d    = abs_a;
          b_d    = abs_b;
          acc_d  = {{XLEN{1'b0}}, abs_b};
          rem_d  = '0;
          cnt_d  = '0;
          wrap_d = 1'b0;
          if (is_div && b_q == '0) begin
            result_d = f3_q[1] ? a_q : '1;
            state_d  = S_DONE;
          end else if (is_div && !f3_q[0] && a_q == MIN_NEG && b_q == '1) begin
            result_d = f3_q[1] ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (wrap_q) begin
          state_d = S_FIX;
        end else begin
          if (is_div) begin
            rem_d = borrow ? div_shift[XLEN:0] : div_diff;
            a_d   = {a_q[XLEN-2:0], ~borrow};
          end else begin
            acc_d = mul_next;
          end
          cnt_d  = cnt_q + 1'b1;
          wrap_d = (cnt_q == CNT_W'(XLEN - 1));
        end
      end
      S_FIX: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: results, latency, kill/start/reset behaviour.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_exp = 32'h0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Cycle index n below is the cycle following edge En, where E0 samples start.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit special,
                       input int kill_at, input int pulse_at);
    int          done_n, ndone, nbusy;
    logic [31:0] got;
    done_n = -1; ndone = 0; nbusy = 0; got = 32'hxxxx_xxxx;
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = ~f3; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    for (int n = 0; n <= 38; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin ndone++; done_n = n; got = result; end
      if (n == pulse_at) begin
        start = 1'b1; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1;
      end else begin
        start = 1'b0;
      end
      kill = (n == kill_at);
    end
    kill = 1'b0;
    if (kill_at >= 0) begin
      chk({tag, ".busy_cycles"}, 32'(nbusy), 32'(kill_at + 1));
      chk({tag, ".done_count"}, 32'(ndone), 32'd0);
      chk({tag, ".result_kept"}, result, last_exp);
    end else begin
      chk({tag, ".done_count"}, 32'(ndone), 32'd1);
      chk({tag, ".done_cycle"}, 32'(done_n), special ? 32'd1 : 32'd35);
      chk({tag, ".busy_cycles"}, 32'(nbusy), special ? 32'd2 : 32'd36);
      chk({tag, ".result"}, got, exp);
      last_exp = exp;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", {31'b0, busy}, 32'd0);
    chk("reset.done", {31'b0, done}, 32'd0);
    chk("reset.result", result, 32'd0);
    rst = 1'b0;

    do_op("mul_7x-3",   3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, -1, -1);
    do_op("mulh_min2",  3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, -1, -1);
    do_op("mulhu_max",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, -1, -1);
    do_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1);
    do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, -1, -1);
    do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, -1, -1);
    do_op("divu_100_7", 3'b101, 32'd100,        32'd7,         32'd14,        1'b0, -1, -1);
    do_op("remu_100_7", 3'b111, 32'd100,        32'd7,         32'd2,         1'b0, -1, -1);
    do_op("divu_by0",   3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, -1, -1);
    do_op("rem_by0",    3'b110, 32'd5,          32'd0,         32'd5,         1'b1, -1, -1);
    do_op("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, -1, -1);
    do_op("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1, -1, -1);

    do_op("kill_run",   3'b000, 32'd5,          32'd6,         32'd30,        1'b0,  9, -1);
    do_op("start_in_run", 3'b000, 32'd9,        32'd11,        32'd99,        1'b0, -1,  5);

    // start and kill together in IDLE must not be accepted
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("start_kill.busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("start_kill.busy2", {31'b0, busy}, 32'd0);

    // asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd13; op_b = 32'd17;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid.busy_before", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.busy", {31'b0, busy}, 32'd0);
    chk("rst_mid.done", {31'b0, done}, 32'd0);
    chk("rst_mid.result", result, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold.busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    last_exp = 32'd0;
    do_op("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
